// File: rtl/tuner_meas_ctrl.sv
// Measurement sequencer for the tuner: triggers the pitch core, averages a burst of
// in-range samples, rejects unstable bursts and holds each published result.
module tuner_meas_ctrl #(
    parameter int INDEX_WIDTH = 11,
    parameter int FREQ_WIDTH  = INDEX_WIDTH + 16,
    parameter int AVG_LOG2    = 2,
    parameter int STAB_TOL    = 3,
    parameter int MIN_FREQ    = 28,
    parameter int MAX_FREQ    = 320,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int HOLD_CYC    = 12_500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  meas_start,
    input  logic                  meas_done,
    input  logic [FREQ_WIDTH-1:0] meas_freq,
    output logic [FREQ_WIDTH-1:0] freq_out,
    output logic                  freq_valid,
    output logic                  timeout_err,
    output logic [AVG_LOG2:0]     burst_count
);

    localparam int SUM_WIDTH = FREQ_WIDTH + AVG_LOG2;
    localparam int TMR_MAX   = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
    localparam int TMR_WIDTH = $clog2(TMR_MAX + 1);

    localparam logic [FREQ_WIDTH-1:0] MIN_F     = FREQ_WIDTH'(MIN_FREQ);
    localparam logic [FREQ_WIDTH-1:0] MAX_F     = FREQ_WIDTH'(MAX_FREQ);
    localparam logic [FREQ_WIDTH-1:0] TOL_F     = FREQ_WIDTH'(STAB_TOL);
    localparam logic [TMR_WIDTH-1:0]  TMO_LAST  = TMR_WIDTH'(TIMEOUT_CYC - 1);
    localparam logic [TMR_WIDTH-1:0]  HOLD_LAST = TMR_WIDTH'(HOLD_CYC - 1);
    localparam logic [AVG_LOG2:0]     BURST_N   = {1'b1, {AVG_LOG2{1'b0}}};

    typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, HOLD} state_t;

    state_t                state;
    logic [SUM_WIDTH-1:0]  sum_acc;
    logic [FREQ_WIDTH-1:0] min_acc;
    logic [FREQ_WIDTH-1:0] max_acc;
    logic [TMR_WIDTH-1:0]  tmr;

    logic                  sample_ok;
    logic [AVG_LOG2:0]     count_inc;
    logic [FREQ_WIDTH-1:0] spread;

    assign sample_ok = meas_done && (meas_freq >= MIN_F) && (meas_freq <= MAX_F);
    assign count_inc = burst_count + 1'b1;
    assign spread    = max_acc - min_acc;

    // meas_start is raised on every transition into START so it is high exactly
    // while the FSM sits in START; START always leaves after one cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state       <= IDLE;
            meas_start  <= 1'b0;
            freq_out    <= '0;
            freq_valid  <= 1'b0;
            timeout_err <= 1'b0;
            burst_count <= '0;
            sum_acc     <= '0;
            min_acc     <= '0;
            max_acc     <= '0;
            tmr         <= '0;
        end else begin
            meas_start <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                freq_valid  <= 1'b0;
                burst_count <= '0;
                sum_acc     <= '0;
                min_acc     <= '0;
                max_acc     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= START;
                        meas_start <= 1'b1;
                    end
                    START: begin
                        tmr   <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        tmr <= tmr + 1'b1;
                        if (sample_ok) begin
                            sum_acc     <= sum_acc + SUM_WIDTH'(meas_freq);
                            burst_count <= count_inc;
                            timeout_err <= 1'b0;
                            if (burst_count == '0 || meas_freq < min_acc) min_acc <= meas_freq;
                            if (burst_count == '0 || meas_freq > max_acc) max_acc <= meas_freq;
                            if (count_inc == BURST_N) begin
                                state <= CHECK;
                            end else begin
                                state      <= START;
                                meas_start <= 1'b1;
                            end
                        end else if (meas_done) begin
                            // Out-of-range sample poisons the whole burst.
                            sum_acc     <= '0;
                            min_acc     <= '0;
                            max_acc     <= '0;
                            burst_count <= '0;
                            state       <= START;
                            meas_start  <= 1'b1;
                        end else if (tmr == TMO_LAST) begin
                            timeout_err <= 1'b1;
                            freq_valid  <= 1'b0;
                            sum_acc     <= '0;
                            min_acc     <= '0;
                            max_acc     <= '0;
                            burst_count <= '0;
                            state       <= START;
                            meas_start  <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (spread <= TOL_F) begin
                            freq_out   <= sum_acc[SUM_WIDTH-1:AVG_LOG2];
                            freq_valid <= 1'b1;
                            tmr        <= '0;
                            state      <= HOLD;
                        end else begin
                            freq_valid <= 1'b0;
                            state      <= START;
                            meas_start <= 1'b1;
                        end
                        sum_acc     <= '0;
                        min_acc     <= '0;
                        max_acc     <= '0;
                        burst_count <= '0;
                    end
                    HOLD: begin
                        if (tmr == HOLD_LAST) begin
                            state      <= START;
                            meas_start <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tuner_meas_ctrl.sv
// Scoreboard bench for tuner_meas_ctrl: a responder answers each meas_start, a small
// burst model queues expected publications that a monitor compares when they fall due.
`timescale 1ns/1ps
module tb_tuner_meas_ctrl;

    localparam int FW          = 27;
    localparam int AVG_LOG2    = 2;
    localparam int N           = 4;
    localparam int STAB_TOL    = 3;
    localparam int MIN_FREQ    = 28;
    localparam int MAX_FREQ    = 320;
    localparam int TIMEOUT_CYC = 50;
    localparam int HOLD_CYC    = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              meas_start;
    logic              meas_done;
    logic [FW-1:0]     meas_freq;
    logic [FW-1:0]     freq_out;
    logic              freq_valid;
    logic              timeout_err;
    logic [AVG_LOG2:0] burst_count;

    always #5 clk = ~clk;

    tuner_meas_ctrl #(
        .INDEX_WIDTH(11),
        .FREQ_WIDTH (FW),
        .AVG_LOG2   (AVG_LOG2),
        .STAB_TOL   (STAB_TOL),
        .MIN_FREQ   (MIN_FREQ),
        .MAX_FREQ   (MAX_FREQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .meas_start (meas_start),
        .meas_done  (meas_done),
        .meas_freq  (meas_freq),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .timeout_err(timeout_err),
        .burst_count(burst_count)
    );

    typedef struct {
        int            due;
        logic          valid;
        logic [FW-1:0] freq;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    exp_t e_push;

    int   n_checks    = 0;
    int   n_errors    = 0;
    int   cyc         = 0;
    int   start_cnt   = 0;
    int   consec_viol = 0;
    logic prev_start  = 1'b0;

    // Reference model state
    logic          exp_valid = 1'b0;
    logic          exp_tmo   = 1'b0;
    logic [FW-1:0] exp_freq  = '0;
    int            m_cnt = 0, m_sum = 0, m_min = 0, m_max = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_start) start_cnt++;
        if (prev_start && meas_start) consec_viol++;
        prev_start = meas_start;
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e_mon = sb_q.pop_front();
            check("sb_due", cyc, e_mon.due);
            check("sb_valid", freq_valid, e_mon.valid);
            check("sb_freq", freq_out, e_mon.freq);
        end
    end

    task automatic wait_start();
        int n = 0;
        while (!meas_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", meas_start, 1'b1);
    endtask

    // Answers the next meas_start after dly cycles; returns on the negedge after done.
    task automatic sample(input int f, input int dly);
        int d;
        wait_start();
        repeat (dly) @(negedge clk);
        meas_done = 1'b1;
        meas_freq = FW'(f);
        d = cyc;
        @(negedge clk);
        meas_done = 1'b0;
        meas_freq = '0;
        check("valid_hold", freq_valid, exp_valid);
        if (f >= MIN_FREQ && f <= MAX_FREQ) begin
            if (m_cnt == 0) begin
                m_min = f;
                m_max = f;
            end else begin
                if (f < m_min) m_min = f;
                if (f > m_max) m_max = f;
            end
            m_sum += f;
            m_cnt++;
            exp_tmo = 1'b0;
        end else begin
            m_cnt = 0;
            m_sum = 0;
        end
        check("burst_count", burst_count, m_cnt);
        check("timeout_err", timeout_err, exp_tmo);
        if (m_cnt == N) begin
            if (m_max - m_min <= STAB_TOL) begin
                exp_valid = 1'b1;
                exp_freq  = FW'(m_sum / N);
            end else begin
                exp_valid = 1'b0;
            end
            e_push.due   = d + 2;
            e_push.valid = exp_valid;
            e_push.freq  = exp_freq;
            sb_q.push_back(e_push);
            m_cnt = 0;
            m_sum = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int t_hold;
        reset     = 1'b1;
        enable    = 1'b0;
        meas_done = 1'b0;
        meas_freq = '0;
        repeat (3) @(negedge clk);
        check("rst_meas_start", meas_start, 1'b0);
        check("rst_freq_out", freq_out, 0);
        check("rst_freq_valid", freq_valid, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_burst_count", burst_count, 0);

        // Stable burst, then the hold window
        reset  = 1'b0;
        enable = 1'b1;
        s0     = start_cnt;
        sample(82, 3); sample(83, 3); sample(82, 3); sample(81, 3);
        check("burst_a_starts", start_cnt - s0, 4);
        t_hold = cyc + 1;
        wait_start();
        check("hold_len", cyc - t_hold, HOLD_CYC);
        check("valid_after_hold", freq_valid, 1'b1);

        // Unstable burst: spread 6
        sample(98, 3); sample(98, 3); sample(104, 3); sample(98, 3);
        @(negedge clk);
        check("unstable_restart", meas_start, 1'b1);
        check("unstable_count", burst_count, 0);

        // Out-of-range second sample, then a clean burst
        sample(90, 3); sample(400, 3);
        sample(90, 3); sample(91, 3); sample(90, 3); sample(91, 3);

        // Core never answers
        wait_start();
        repeat (TIMEOUT_CYC) @(negedge clk);
        check("tmo_early", timeout_err, 1'b0);
        check("tmo_valid_pre", freq_valid, exp_valid);
        @(negedge clk);
        exp_tmo   = 1'b1;
        exp_valid = 1'b0;
        m_cnt     = 0;
        m_sum     = 0;
        check("tmo_set", timeout_err, 1'b1);
        check("tmo_valid", freq_valid, 1'b0);
        check("tmo_restart", meas_start, 1'b1);
        check("tmo_count", burst_count, 0);

        // Valid sample clears the error; next one lands on the timeout cycle itself
        sample(100, 3);
        sample(101, TIMEOUT_CYC);
        sample(99, 3); sample(100, 3);

        // Drop enable mid-burst at count 2
        sample(120, 3); sample(121, 3);
        enable = 1'b0;
        @(negedge clk);
        m_cnt     = 0;
        m_sum     = 0;
        exp_valid = 1'b0;
        check("dis_meas_start", meas_start, 1'b0);
        check("dis_count", burst_count, 0);
        check("dis_valid", freq_valid, 1'b0);
        check("dis_freq_kept", freq_out, exp_freq);
        check("dis_tmo_kept", timeout_err, exp_tmo);
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        check("idle_no_start", start_cnt - s0, 0);
        enable = 1'b1;

        // Publish, then reset in the middle of HOLD
        sample(60, 3); sample(61, 3); sample(62, 3); sample(61, 3);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("hrst_meas_start", meas_start, 1'b0);
        check("hrst_freq_out", freq_out, 0);
        check("hrst_freq_valid", freq_valid, 1'b0);
        check("hrst_timeout_err", timeout_err, 1'b0);
        check("hrst_burst_count", burst_count, 0);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        check("start_consec", consec_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tuner_meas_ctrl.md
Name: tuner_meas_ctrl

Overview:
- Sequencer between the pitch-measurement core and the tuner display logic.
- Repeatedly triggers a measurement and collects 2^AVG_LOG2 in-range results.
- Rejects bursts whose spread exceeds STAB_TOL. Otherwise publishes the averaged frequency, in integer Hz, with freq_valid, and holds it for HOLD_CYC.
- Flags a measurement core that never answers, via TIMEOUT_CYC.

Parameters:
- INDEX_WIDTH, 11, bin-index width of the measurement core.
- FREQ_WIDTH, INDEX_WIDTH+16, width of frequency words in Hz.
- AVG_LOG2, 2, log2 of the number of samples averaged per burst (1..4).
- STAB_TOL, 3, maximum allowed max-min spread within a burst, in Hz.
- MIN_FREQ, 28, lowest accepted sample in Hz, inclusive.
- MAX_FREQ, 320, highest accepted sample in Hz, inclusive.
- TIMEOUT_CYC, 1_000_000, clocks to wait for meas_done before declaring timeout.
- HOLD_CYC, 12_500_000, clocks to hold a published result before the next burst.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run sequencing; low forces IDLE
- meas_start  out  1  one-cycle pulse requesting one measurement
- meas_done  in  1  one-cycle pulse: meas_freq is valid this cycle
- meas_freq  in  FREQ_WIDTH  measured frequency, Hz
- freq_out  out  FREQ_WIDTH  published averaged frequency
- freq_valid  out  1  freq_out is a current stable result
- timeout_err  out  1  last measurement timed out; sticky until next accepted sample
- burst_count  out  AVG_LOG2+1  samples accumulated in the current burst

Behaviour:
- Reset values: state IDLE, meas_start=0, freq_out=0, freq_valid=0, timeout_err=0, burst_count=0. Sum/min/max accumulators are also cleared.
- Reset has priority over every other event, including mid-measurement.
- enable=0 in any state:
  - next state IDLE
  - accumulators cleared
  - freq_valid=0, freq_out keeps its value
  - timeout_err keeps its value
- Sum register is FREQ_WIDTH+AVG_LOG2 bits wide; no overflow is possible. Min/max registers are FREQ_WIDTH bits.
- IDLE: if enable=1, go to START next cycle.
- START: meas_start=1 for exactly this cycle; load the timeout counter with 0; go to WAIT. A meas_done arriving in START is ignored.
- WAIT: the timeout counter increments each cycle. Priority order:
  1. meas_done=1 with MIN_FREQ <= meas_freq <= MAX_FREQ:
     - add meas_freq to the sum
     - update min/max (the first sample of a burst loads both)
     - burst_count+1
     - timeout_err=0
     - if the new count == 2^AVG_LOG2, go to CHECK; else go to START
  2. meas_done=1 with meas_freq out of range:
     - discard the sample, clear accumulators, burst_count=0
     - go to START
     - freq_valid unchanged
  3. Otherwise, if the counter == TIMEOUT_CYC-1:
     - timeout_err=1, freq_valid=0, clear accumulators
     - go to START
  - If meas_done coincides with the timeout cycle, meas_done wins.
- CHECK (1 cycle):
  - Stable (max-min <= STAB_TOL):
    - freq_out = sum >> AVG_LOG2 (truncating)
    - freq_valid=1
    - go to HOLD
  - Unstable:
    - freq_valid=0
    - go to START
  - In both cases, clear accumulators and set burst_count=0.
- HOLD:
  - Count HOLD_CYC cycles, then go to START.
  - freq_out and freq_valid are stable throughout HOLD.
  - meas_start stays 0; meas_done is ignored.
- Latency: the final accepted meas_done reaches freq_valid/freq_out 2 cycles later (WAIT -> CHECK registered -> output registered).
- All outputs are registered. meas_start is never asserted two consecutive cycles.

Test Plan:
- Reset then enable=1, AVG_LOG2=2. Return meas_done 3 cycles after each start with 82, 83, 82, 81 Hz:
  - exactly 4 meas_start pulses
  - 2 cycles after the 4th done: freq_out=82 (328>>2), freq_valid=1
  - no meas_start for HOLD_CYC cycles (use HOLD_CYC=20)
- Unstable burst with samples 98, 98, 104, 98 (spread 6 > 3):
  - freq_valid=0 after CHECK
  - burst_count returns to 0 and a new meas_start follows
- Out-of-range sample: 2nd sample 400 Hz:
  - burst_count drops to 0
  - next burst of 4 in-range samples publishes normally
- TIMEOUT_CYC=50, never pulse meas_done:
  - timeout_err=1 and freq_valid=0 at cycle 50 after meas_start
  - new meas_start next cycle
  - a subsequent valid sample clears timeout_err
- meas_done asserted on exactly the timeout cycle: sample accepted, timeout_err stays 0.
- Drop enable mid-burst (count=2), and separately assert reset during HOLD:
  - enable case: IDLE, burst_count=0, freq_valid=0 next cycle
  - reset case: all outputs return to reset values next cycle
